// File: rtl/limine2600_bus_arbiter.sv
// rtl/limine2600_bus_arbiter.sv - N-master round-robin arbiter in front of one req/rdy slave.
// Optional bus timeout abort is enabled by defining LIMINE2600_ARB_TIMEOUT_EN.
module limine2600_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic                          s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rdy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         ptr_q;
  logic [IDX_W-1:0]         ptr_next;
  logic [NUM_MASTERS-1:0]   grant_oh;

  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_we;
  logic [ADDR_W-1:0]        pick_addr;
  logic [DATA_W-1:0]        pick_wdata;

  logic                     grant_now;
  logic                     complete;
  logic                     timeout_hit;
  logic                     finish;

  // Rotating priority: first requester at or after ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      int c;
      c = int'(ptr_q) + i;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      if (!pick_found && m_req[c]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(c);
        pick_we    = m_we[c];
        pick_addr  = m_addr[c*ADDR_W +: ADDR_W];
        pick_wdata = m_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_now = (state_q == ST_IDLE) && pick_found;
  assign complete  = (state_q == ST_BUSY) && s_rdy;
  assign finish    = complete || timeout_hit;
  assign ptr_next  = (idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx_q + IDX_W'(1);
  assign grant_oh  = NUM_MASTERS'(1) << idx_q;

`ifdef LIMINE2600_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // The limit is reached on the edge that ends the TIMEOUT-th BUSY cycle; s_rdy wins a tie.
  assign timeout_hit = (state_q == ST_BUSY) && !s_rdy && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign m_err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant_now) begin
        cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign m_err       = 1'b0;

  if (TIMEOUT < 1) begin : g_timeout_must_be_positive
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_found) state_d = ST_BUSY;
      ST_BUSY: if (finish) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_req  = 1'b0;
    m_gnt  = '0;
    m_done = '0;
    case (state_q)
      ST_BUSY: begin
        s_req = 1'b1;
        m_gnt = grant_oh;
      end
      ST_DONE: begin
        m_gnt  = grant_oh;
        m_done = grant_oh;
      end
      default: ;
    endcase
  end

  // Slave-side request fields are latched at grant and held through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      ptr_q   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_rdata <= '0;
    end else begin
      if (grant_now) begin
        idx_q   <= pick_idx;
        s_we    <= pick_we;
        s_addr  <= pick_addr;
        s_wdata <= pick_wdata;
      end
      if (complete) begin
        if (!s_we) m_rdata <= s_rdata;
        ptr_q <= ptr_next;
      end else if (timeout_hit) begin
        m_rdata <= '0;
        ptr_q   <= ptr_next;
      end
    end
  end

endmodule
